// File: rtl/inst_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master = byte source / memory side, slave = the loader.
interface inst_mem_loader_if #(
    parameter int unsigned AW = 6
);
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [31:0]   mem_wd;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_wa, mem_wd
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_wa, mem_wd
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Boot-time loader: assembles big-endian words from a byte stream, writes them
// into instruction memory and holds the MIPS core in reset until the image is complete.
module inst_mem_loader #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AW:0]       load_len,
    inst_mem_loader_if.slave  bus,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_W   = (AW + 1)'(1);

    state_t        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   word_idx_q, word_idx_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [31:0]   asm_q, asm_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_wa_q, mem_wa_d;
    logic [31:0]   mem_wd_q, mem_wd_d;
    logic          core_rst_q, core_rst_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic start_legal;
    logic byte_accept;
    logic last_word;

    assign start_legal = (load_len != '0) && (load_len <= DEPTH_W);
    assign byte_accept = bus.byte_valid && (state_q == ST_RECV);
    assign last_word   = (word_idx_q == (len_q - ONE_W));

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        mem_we_d   = 1'b0;
        mem_wa_d   = mem_wa_q;
        mem_wd_d   = mem_wd_q;
        core_rst_d = core_rst_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;

        case (state_q)
            // IDLE and DONE share start handling; only core_rst differs, and it
            // is driven high on a legal start in both cases.
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (start_legal) begin
                        len_d      = load_len;
                        word_idx_d = '0;
                        byte_idx_d = '0;
                        done_d     = 1'b0;
                        error_d    = 1'b0;
                        busy_d     = 1'b1;
                        core_rst_d = 1'b1;
                        state_d    = ST_RECV;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end

            ST_RECV: begin
                if (byte_accept) begin
                    case (byte_idx_q)
                        2'd0:    asm_d[31:24] = bus.byte_data;
                        2'd1:    asm_d[23:16] = bus.byte_data;
                        2'd2:    asm_d[15:8]  = bus.byte_data;
                        default: asm_d[7:0]   = bus.byte_data;
                    endcase
                    byte_idx_d = byte_idx_q + 2'd1;
                    // Write port is registered, so it is loaded as the 4th byte lands.
                    if (byte_idx_q == 2'd3) begin
                        mem_we_d = 1'b1;
                        mem_wa_d = word_idx_q[AW-1:0];
                        mem_wd_d = {asm_q[31:8], bus.byte_data};
                        state_d  = ST_WRITE;
                    end
                end
            end

            ST_WRITE: begin
                if (last_word) begin
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    core_rst_d = 1'b0;
                    state_d    = ST_DONE;
                end else begin
                    word_idx_d = word_idx_q + ONE_W;
                    state_d    = ST_RECV;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            mem_we_q   <= 1'b0;
            mem_wa_q   <= '0;
            mem_wd_q   <= '0;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            mem_we_q   <= mem_we_d;
            mem_wa_q   <= mem_wa_d;
            mem_wd_q   <= mem_wd_d;
            core_rst_q <= core_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign bus.byte_ready = (state_q == ST_RECV);
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_wa     = mem_wa_q;
    assign bus.mem_wd     = mem_wd_q;
    assign core_rst       = core_rst_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed self-checking bench for inst_mem_loader: byte-stream loads, gaps,
// illegal lengths, full-depth load, ignored restart and mid-load reset.
module tb_inst_mem_loader;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   load_len;
    logic          core_rst;
    logic          busy;
    logic          done;
    logic          error;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned wr_count = 0;
    int unsigned w0;

    inst_mem_loader_if #(.AW(AW)) bus ();

    inst_mem_loader #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .load_len(load_len),
        .bus     (bus.slave),
        .core_rst(core_rst),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) wr_count++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, exp $finish before limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"},    32'(bus.byte_ready), 32'd0);
        check({tag, "_we"},       32'(bus.mem_we),     32'd0);
        check({tag, "_wa"},       32'(bus.mem_wa),     32'd0);
        check({tag, "_wd"},       bus.mem_wd,          32'd0);
        check({tag, "_core_rst"}, 32'(core_rst),       32'd1);
        check({tag, "_busy"},     32'(busy),           32'd0);
        check({tag, "_done"},     32'(done),           32'd0);
        check({tag, "_error"},    32'(error),          32'd0);
    endtask

    task automatic pulse_start(input logic [AW:0] len);
        start    = 1'b1;
        load_len = len;
        tick();
        start    = 1'b0;
    endtask

    // Entered and left while the loader sits in RECV.
    task automatic send_byte(input logic [7:0] b, input int unsigned gaps);
        for (int unsigned g = 0; g < gaps; g++) begin
            bus.byte_valid = 1'b0;
            tick();
            check("gap_ready", 32'(bus.byte_ready), 32'd1);
            check("gap_we",    32'(bus.mem_we),     32'd0);
        end
        check("byte_ready", 32'(bus.byte_ready), 32'd1);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        tick();
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [AW-1:0] wa, input int unsigned gaps);
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            b = w[31-8*k -: 8];
            send_byte(b, gaps);
        end
        check("we",   32'(bus.mem_we), 32'd1);
        check("wa",   32'(bus.mem_wa), 32'(wa));
        check("wd",   bus.mem_wd,      w);
        check("write_ready", 32'(bus.byte_ready), 32'd0);
        tick();
        check("we_pulse", 32'(bus.mem_we), 32'd0);
    endtask

    task automatic check_done(input string tag, input int unsigned exp_writes);
        check({tag, "_done"},     32'(done),     32'd1);
        check({tag, "_core_rst"}, 32'(core_rst), 32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_error"},    32'(error),    32'd0);
        check({tag, "_nwrites"},  wr_count - w0, exp_writes);
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        load_len       = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        repeat (3) tick();
        check_reset_vals("por");
        rst = 1'b0;
        tick();

        // Two-word image, back-to-back bytes
        w0 = wr_count;
        pulse_start(7'd2);
        check("t1_busy",     32'(busy),     32'd1);
        check("t1_core_rst", 32'(core_rst), 32'd1);
        send_word(32'h8C010004, 6'd0, 0);
        send_word(32'hAC020008, 6'd1, 0);
        check_done("t1", 2);

        // Same image with 3 idle cycles before every byte
        w0 = wr_count;
        pulse_start(7'd2);
        check("t2_core_rst", 32'(core_rst), 32'd1);
        check("t2_done",     32'(done),     32'd0);
        check("t2_busy",     32'(busy),     32'd1);
        send_word(32'h8C010004, 6'd0, 3);
        send_word(32'hAC020008, 6'd1, 3);
        check_done("t2", 2);

        // Illegal lengths from IDLE, then recovery
        rst = 1'b1;
        tick();
        rst = 1'b0;
        w0 = wr_count;
        pulse_start(7'd0);
        check("t3_len0_error",    32'(error),    32'd1);
        check("t3_len0_busy",     32'(busy),     32'd0);
        check("t3_len0_core_rst", 32'(core_rst), 32'd1);
        check("t3_len0_ready",    32'(bus.byte_ready), 32'd0);
        pulse_start(7'd65);
        check("t3_len65_error",    32'(error),    32'd1);
        check("t3_len65_busy",     32'(busy),     32'd0);
        check("t3_len65_core_rst", 32'(core_rst), 32'd1);
        tick();
        tick();
        check("t3_no_write", wr_count - w0, 32'd0);
        pulse_start(7'd1);
        check("t3_error_clr", 32'(error), 32'd0);
        check("t3_busy",      32'(busy),  32'd1);
        send_word(32'h20080005, 6'd0, 0);
        check_done("t3", 1);
        pulse_start(7'd0);
        check("t3_done_err",      32'(error),    32'd1);
        check("t3_done_core_rst", 32'(core_rst), 32'd0);
        check("t3_done_busy",     32'(busy),     32'd0);

        // Full-depth load
        w0 = wr_count;
        pulse_start(7'd64);
        check("t4_error_clr", 32'(error),    32'd0);
        check("t4_done_clr",  32'(done),     32'd0);
        check("t4_core_rst",  32'(core_rst), 32'd1);
        for (int unsigned i = 0; i < 64; i++)
            send_word(32'(i), 6'(i), 0);
        check_done("t4", 64);

        // start during a load is ignored and load_len is not resampled
        w0 = wr_count;
        pulse_start(7'd5);
        send_word(32'h11110000, 6'd0, 0);
        send_word(32'h11110001, 6'd1, 0);
        check("t5_two_written", wr_count - w0, 32'd2);
        pulse_start(7'd2);
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_done", 32'(done), 32'd0);
        send_word(32'h11110002, 6'd2, 0);
        send_word(32'h11110003, 6'd3, 0);
        check("t5_not_done", 32'(done), 32'd0);
        send_word(32'h11110004, 6'd4, 0);
        check_done("t5", 5);

        // Reset after two bytes of word 3
        pulse_start(7'd4);
        send_word(32'h22220000, 6'd0, 0);
        send_word(32'h22220001, 6'd1, 0);
        send_word(32'h22220002, 6'd2, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        w0 = wr_count;
        rst = 1'b1;
        tick();
        check_reset_vals("t6_rst");
        rst = 1'b0;
        tick();
        check("t6_no_partial", wr_count - w0, 32'd0);
        check("t6_core_rst",   32'(core_rst), 32'd1);
        pulse_start(7'd1);
        send_word(32'hCAFEF00D, 6'd0, 0);
        check_done("t6", 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
